// File: rtl/firebird7_in_gate1_tessent_data_mux_guarded.sv
// Guarded IJTAG/functional data mux for gate1: registered output that freezes
// for GUARD cycles on every source switch and snapshots the functional word on entry.
module firebird7_in_gate1_tessent_data_mux_guarded #(
    parameter int unsigned      WIDTH       = 19,
    parameter int unsigned      NUM_SRC     = 2,
    parameter int unsigned      GUARD       = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned      SW          = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                     ijtag_tck,
    input  logic                     ijtag_reset,
    input  logic                     ijtag_select,
    input  logic [SW-1:0]            ijtag_src_sel,
    input  logic [WIDTH-1:0]         functional_data_in,
    input  logic [NUM_SRC*WIDTH-1:0] ijtag_data_in,
    output logic [WIDTH-1:0]         data_out,
    output logic [WIDTH-1:0]         capture_data,
    output logic                     mux_active,
    output logic                     switch_busy
);

    localparam int unsigned   CW       = 4;
    localparam logic [CW-1:0] GUARD_LD = CW'(GUARD);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_FUNC     = 2'd0,
        ST_HOLD_IN  = 2'd1,
        ST_IJTAG    = 2'd2,
        ST_HOLD_OUT = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nxt;
    logic [WIDTH-1:0]  data_nxt;
    logic [WIDTH-1:0]  capture_nxt;
    logic [WIDTH-1:0]  src_word;
    logic              src_valid;

    // Source decode; an index past NUM_SRC leaves src_valid low so the output holds.
    always_comb begin
        src_word  = '0;
        src_valid = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (ijtag_src_sel == SW'(i)) begin
                src_word  = ijtag_data_in[i*WIDTH +: WIDTH];
                src_valid = 1'b1;
            end
        end
    end

    // Next-state, guard counter and output word selection.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        data_nxt    = data_out;
        capture_nxt = capture_data;
        case (state)
            ST_FUNC: begin
                if (ijtag_select) begin
                    capture_nxt = functional_data_in;
                    if (GUARD != 0) begin
                        state_nxt = ST_HOLD_IN;
                        cnt_nxt   = GUARD_LD;
                    end else begin
                        state_nxt = ST_IJTAG;
                    end
                end else begin
                    data_nxt = functional_data_in;
                end
            end
            ST_HOLD_IN: begin
                if (!ijtag_select) begin
                    state_nxt = ST_HOLD_OUT;
                    cnt_nxt   = GUARD_LD;
                end else if (cnt == CNT_ONE) begin
                    state_nxt = ST_IJTAG;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            ST_IJTAG: begin
                if (!ijtag_select) begin
                    if (GUARD != 0) begin
                        state_nxt = ST_HOLD_OUT;
                        cnt_nxt   = GUARD_LD;
                    end else begin
                        state_nxt = ST_FUNC;
                    end
                end else if (src_valid) begin
                    data_nxt = src_word;
                end
            end
            ST_HOLD_OUT: begin
                // Re-request while leaving restarts the entry guard without recapturing.
                if (ijtag_select) begin
                    state_nxt = ST_HOLD_IN;
                    cnt_nxt   = GUARD_LD;
                end else if (cnt == CNT_ONE) begin
                    state_nxt = ST_FUNC;
                end else begin
                    cnt_nxt = cnt - CNT_ONE;
                end
            end
            default: begin
                state_nxt = ST_FUNC;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State register; status flags are flopped alongside so they mirror the state register.
    always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
        if (!ijtag_reset) begin
            state        <= ST_FUNC;
            cnt          <= '0;
            data_out     <= RESET_VALUE;
            capture_data <= '0;
            mux_active   <= 1'b0;
            switch_busy  <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            data_out     <= data_nxt;
            capture_data <= capture_nxt;
            mux_active   <= (state_nxt == ST_IJTAG);
            switch_busy  <= (state_nxt == ST_HOLD_IN) || (state_nxt == ST_HOLD_OUT);
        end
    end

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_data_mux_guarded.sv
// Bench for the guarded gate1 data mux: two configurations (GUARD=2/NUM_SRC=2 and
// GUARD=0/NUM_SRC=3) driven together and compared against an owner/freeze model.
module tb_firebird7_in_gate1_tessent_data_mux_guarded;

    localparam int unsigned W = 19;

    logic           clk;
    logic           rst_n;
    logic           select;
    logic [0:0]     sel_a;
    logic [1:0]     sel_b;
    logic [W-1:0]   func_data;
    logic [W-1:0]   src_w [3];
    logic [2*W-1:0] a_din;
    logic [3*W-1:0] b_din;

    logic [W-1:0] a_data, a_cap, b_data, b_cap;
    logic         a_mux, a_busy, b_mux, b_busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: settled owner (0 func, 1 ijtag), pending target and remaining frozen edges.
    int           g_cfg  [2] = '{2, 0};
    int           n_cfg  [2] = '{2, 3};
    logic [W-1:0] rv_cfg [2] = '{19'h00000, 19'h5A5A5};
    bit           owner  [2];
    bit           target [2];
    int           left   [2];
    logic [W-1:0] m_data [2];
    logic [W-1:0] m_cap  [2];

    assign a_din = {src_w[1], src_w[0]};
    assign b_din = {src_w[2], src_w[1], src_w[0]};

    firebird7_in_gate1_tessent_data_mux_guarded #(
        .WIDTH(W), .NUM_SRC(2), .GUARD(2), .RESET_VALUE(19'h00000)
    ) dut_a (
        .ijtag_tck          (clk),
        .ijtag_reset        (rst_n),
        .ijtag_select       (select),
        .ijtag_src_sel      (sel_a),
        .functional_data_in (func_data),
        .ijtag_data_in      (a_din),
        .data_out           (a_data),
        .capture_data       (a_cap),
        .mux_active         (a_mux),
        .switch_busy        (a_busy)
    );

    firebird7_in_gate1_tessent_data_mux_guarded #(
        .WIDTH(W), .NUM_SRC(3), .GUARD(0), .RESET_VALUE(19'h5A5A5)
    ) dut_b (
        .ijtag_tck          (clk),
        .ijtag_reset        (rst_n),
        .ijtag_select       (select),
        .ijtag_src_sel      (sel_b),
        .functional_data_in (func_data),
        .ijtag_data_in      (b_din),
        .data_out           (b_data),
        .capture_data       (b_cap),
        .mux_active         (b_mux),
        .switch_busy        (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            owner[u]  = 1'b0;
            target[u] = 1'b0;
            left[u]   = 0;
            m_data[u] = rv_cfg[u];
            m_cap[u]  = '0;
        end
    endtask

    // One clock edge of the switching rules for configuration u.
    task automatic model_edge(input int u, input bit req, input int s);
        if (left[u] == 0) begin
            if (req != owner[u]) begin
                if (!owner[u]) m_cap[u] = func_data;
                target[u] = req;
                left[u]   = g_cfg[u];
                if (g_cfg[u] == 0) owner[u] = req;
            end else if (!owner[u]) begin
                m_data[u] = func_data;
            end else if (s < n_cfg[u]) begin
                m_data[u] = src_w[s];
            end
        end else if (req != target[u]) begin
            target[u] = req;
            left[u]   = g_cfg[u];
        end else begin
            left[u]--;
            if (left[u] == 0) owner[u] = target[u];
        end
    endtask

    task automatic cmp_all(input string ph);
        check({ph, "_a_data"}, 32'(a_data), 32'(m_data[0]));
        check({ph, "_a_cap"},  32'(a_cap),  32'(m_cap[0]));
        check({ph, "_a_mux"},  32'(a_mux),  32'(owner[0] && left[0] == 0));
        check({ph, "_a_busy"}, 32'(a_busy), 32'(left[0] > 0));
        check({ph, "_b_data"}, 32'(b_data), 32'(m_data[1]));
        check({ph, "_b_cap"},  32'(b_cap),  32'(m_cap[1]));
        check({ph, "_b_mux"},  32'(b_mux),  32'(owner[1] && left[1] == 0));
        check({ph, "_b_busy"}, 32'(b_busy), 32'(left[1] > 0));
    endtask

    task automatic step(input string ph);
        @(posedge clk);
        model_edge(0, select, int'(sel_a));
        model_edge(1, select, int'(sel_b));
        #1;
        cmp_all(ph);
    endtask

    // Asynchronous reset between edges, checked before any clock edge arrives.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        cmp_all("rst");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b1;
        select    = 1'b0;
        sel_a     = '0;
        sel_b     = '0;
        func_data = '0;
        for (int i = 0; i < 3; i++) src_w[i] = '0;
        model_reset();
        do_reset();

        // Entry with GUARD=2 (A) and GUARD=0 (B)
        func_data = 19'h12345;
        src_w[1]  = 19'h7ABCD;
        src_w[2]  = 19'h0BEEF;
        sel_a     = 1'b1;
        sel_b     = 2'd2;
        step("settle");
        step("settle");
        select = 1'b1;
        step("entry_k");
        check("entry_cap", 32'(a_cap), 32'h12345);
        check("entry_busy", 32'(a_busy), 32'd1);
        check("g0_busy", 32'(b_busy), 32'd0);
        step("entry_k1");
        check("g0_data", 32'(b_data), 32'h0BEEF);
        step("entry_k2");
        check("entry_frozen", 32'(a_data), 32'h12345);
        check("entry_mux", 32'(a_mux), 32'd1);
        step("entry_k3");
        check("entry_new", 32'(a_data), 32'h7ABCD);

        // Exit: last IJTAG word held three edges
        func_data = 19'h22222;
        select    = 1'b0;
        step("exit_k");
        check("exit_mux", 32'(a_mux), 32'd0);
        step("exit_k1");
        step("exit_k2");
        check("exit_hold", 32'(a_data), 32'h7ABCD);
        step("exit_k3");
        check("exit_func", 32'(a_data), 32'h22222);

        // Abort one cycle into the entry guard
        select = 1'b1;
        step("abort_k");
        select    = 1'b0;
        src_w[1]  = 19'h33333;
        step("abort_k1");
        func_data = 19'h44444;
        step("abort_k2");
        step("abort_k3");
        check("abort_hold", 32'(a_data), 32'h22222);
        step("abort_k4");
        check("abort_func", 32'(a_data), 32'h44444);
        check("abort_cap", 32'(a_cap), 32'h22222);

        // Out-of-range source index on the three-source instance
        src_w[2] = 19'h0ABCD;
        select   = 1'b1;
        step("oor_in");
        step("oor_in");
        check("oor_src2", 32'(b_data), 32'h0ABCD);
        sel_b    = 2'd3;
        src_w[2] = 19'h0DCBA;
        step("oor_3");
        check("oor_hold", 32'(b_data), 32'h0ABCD);
        sel_b = 2'd2;
        step("oor_2");
        check("oor_back", 32'(b_data), 32'h0DCBA);

        // Randomized traffic with resets landing mid-switch and mid-override
        for (int i = 0; i < 1500; i++) begin
            func_data = W'($urandom);
            for (int j = 0; j < 3; j++) src_w[j] = W'($urandom);
            sel_a = 1'($urandom);
            sel_b = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) select = ~select;
            if (i == 600 || i == 1100) do_reset();
            step("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
